// File: rtl/acc_cpu_core.sv
// acc_cpu_core: multi-cycle accumulator CPU core.
//   FETCH latches the instruction, EXEC commits ALU/branch results, MEM waits
//   on a req/ready data-memory handshake, HALT is absorbing until reset.
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   imem_addr/data  program ROM address (= PC) and combinational instruction
//   dmem_req/we     data memory request and direction (1 = write)
//   dmem_addr/wdata registered data address and write data (= A)
//   dmem_rdata      read data, sampled when dmem_req & dmem_ready
//   dmem_ready      completes the current transfer at a clk edge
//   acc, flag_z/c   committed accumulator and flags
//   halted          core is in HALT
//   retire          one-cycle pulse per completed instruction
module acc_cpu_core #(
  parameter int DATA_WIDTH     = 8,
  parameter int PC_WIDTH       = 5,
  parameter int RF_ADDR_WIDTH  = 2,
  parameter int MEM_ADDR_WIDTH = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic [PC_WIDTH-1:0]       imem_addr,
  input  logic [15:0]               imem_data,
  output logic                      dmem_req,
  output logic                      dmem_we,
  output logic [MEM_ADDR_WIDTH-1:0] dmem_addr,
  output logic [DATA_WIDTH-1:0]     dmem_wdata,
  input  logic [DATA_WIDTH-1:0]     dmem_rdata,
  input  logic                      dmem_ready,
  output logic [DATA_WIDTH-1:0]     acc,
  output logic                      flag_z,
  output logic                      flag_c,
  output logic                      halted,
  output logic                      retire
);

  localparam int unsigned NUM_REGS = 1 << RF_ADDR_WIDTH;

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HALT} state_t;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0, OP_LDI = 4'h1, OP_ADD = 4'h2, OP_SUB = 4'h3,
    OP_AND = 4'h4, OP_OR  = 4'h5, OP_XOR = 4'h6, OP_ADC = 4'h7,
    OP_STR = 4'h8, OP_LDM = 4'h9, OP_STM = 4'hA, OP_JMP = 4'hB,
    OP_JZ  = 4'hC, OP_JC  = 4'hD, OP_SHL = 4'hE, OP_HLT = 4'hF
  } opcode_t;

  state_t                      state_q, state_d;
  logic [15:0]                 ir_q;
  logic [PC_WIDTH-1:0]         pc_q;
  logic [DATA_WIDTH-1:0]       a_q;
  logic                        z_q, c_q;
  logic [DATA_WIDTH-1:0]       rf_q [NUM_REGS];
  logic                        dmem_we_q;
  logic [MEM_ADDR_WIDTH-1:0]   dmem_addr_q;
  logic [DATA_WIDTH-1:0]       dmem_wdata_q;

  // Instruction field decode
  opcode_t                     op;
  logic [RF_ADDR_WIDTH-1:0]    r_sel;
  logic [DATA_WIDTH-1:0]       imm;
  logic [MEM_ADDR_WIDTH-1:0]   ma;
  logic [PC_WIDTH-1:0]         tgt;
  logic [DATA_WIDTH-1:0]       rval;
  logic [PC_WIDTH-1:0]         pc_inc;
  logic                        is_mem_op;
  logic                        unused_ir;

  assign op        = opcode_t'(ir_q[15:12]);
  assign r_sel     = ir_q[RF_ADDR_WIDTH-1:0];
  assign imm       = ir_q[DATA_WIDTH-1:0];
  assign ma        = ir_q[MEM_ADDR_WIDTH-1:0];
  assign tgt       = ir_q[PC_WIDTH-1:0];
  assign rval      = rf_q[r_sel];
  assign pc_inc    = pc_q + PC_WIDTH'(1);
  assign is_mem_op = (op == OP_LDM) || (op == OP_STM);
  // Operand bits above the widest field are architecturally ignored.
  assign unused_ir = ^ir_q[11:0];

  // ALU / branch evaluation for the instruction held in IR
  logic [DATA_WIDTH:0]   sum;
  logic [DATA_WIDTH-1:0] a_nxt;
  logic                  c_nxt;
  logic                  wr_a;
  logic                  wr_c;
  logic                  taken;

  always_comb begin
    sum   = '0;
    a_nxt = a_q;
    c_nxt = c_q;
    wr_a  = 1'b0;
    wr_c  = 1'b0;
    taken = 1'b0;
    case (op)
      OP_LDI: begin
        a_nxt = imm;
        wr_a  = 1'b1;
      end
      OP_ADD, OP_SUB, OP_ADC, OP_SHL: begin
        case (op)
          OP_ADD:  sum = {1'b0, a_q} + {1'b0, rval};
          // C=1 means no borrow: A + ~R + 1
          OP_SUB:  sum = {1'b0, a_q} + {1'b0, ~rval} + (DATA_WIDTH+1)'(1);
          OP_ADC:  sum = {1'b0, a_q} + {1'b0, rval} + {{DATA_WIDTH{1'b0}}, c_q};
          default: sum = {a_q, 1'b0};
        endcase
        a_nxt = sum[DATA_WIDTH-1:0];
        c_nxt = sum[DATA_WIDTH];
        wr_a  = 1'b1;
        wr_c  = 1'b1;
      end
      OP_AND: begin
        a_nxt = a_q & rval;
        wr_a  = 1'b1;
      end
      OP_OR: begin
        a_nxt = a_q | rval;
        wr_a  = 1'b1;
      end
      OP_XOR: begin
        a_nxt = a_q ^ rval;
        wr_a  = 1'b1;
      end
      OP_JMP:  taken = 1'b1;
      OP_JZ:   taken = z_q;
      OP_JC:   taken = c_q;
      default: ;
    endcase
  end

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state and retire pulse
  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      S_FETCH: state_d = S_EXEC;
      S_EXEC: begin
        if (is_mem_op) begin
          state_d = S_MEM;
        end else if (op == OP_HLT) begin
          state_d = S_HALT;
        end else begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_MEM: begin
        if (dmem_ready) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  // Architectural state and registered memory interface
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir_q         <= '0;
      pc_q         <= '0;
      a_q          <= '0;
      z_q          <= 1'b0;
      c_q          <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      case (state_q)
        S_FETCH: ir_q <= imem_data;
        S_EXEC: begin
          if (wr_a) begin
            a_q <= a_nxt;
            z_q <= (a_nxt == '0);
          end
          if (wr_c) begin
            c_q <= c_nxt;
          end
          if (op == OP_STR) begin
            rf_q[r_sel] <= a_q;
          end
          if (is_mem_op) begin
            // PC advances only when the transfer completes in MEM
            dmem_we_q    <= (op == OP_STM);
            dmem_addr_q  <= ma;
            dmem_wdata_q <= a_q;
          end else if (op != OP_HLT) begin
            pc_q <= taken ? tgt : pc_inc;
          end
        end
        S_MEM: begin
          if (dmem_ready) begin
            if (!dmem_we_q) begin
              a_q <= dmem_rdata;
              z_q <= (dmem_rdata == '0);
            end
            pc_q <= pc_inc;
          end
        end
        default: ;
      endcase
    end
  end

  // dmem_req follows the MEM state so an async reset drops it at once.
  assign dmem_req   = (state_q == S_MEM);
  assign dmem_we    = dmem_we_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_wdata = dmem_wdata_q;
  assign imem_addr  = pc_q;
  assign acc        = a_q;
  assign flag_z     = z_q;
  assign flag_c     = c_q;
  assign halted     = (state_q == S_HALT);

endmodule

// File: doc/acc_cpu_core.md
Name: acc_cpu_core

Overview:
- Parametrised multi-cycle accumulator CPU core: next generation of the single-cycle accumulator datapath.
- Adds a fetch/execute FSM, conditional branches, Z/C flags, HALT, and a req/ready data-memory handshake (variable-latency memory).
- Register file, ALU, accumulator and flags are internal; program and data memories are external.
- Instantiated by the top level between program ROM and data RAM.

Parameters:
- DATA_WIDTH, 8, accumulator/register/memory data width (4..12).
- PC_WIDTH, 5, program counter width (<=12).
- RF_ADDR_WIDTH, 2, register file address width; 2**RF_ADDR_WIDTH registers.
- MEM_ADDR_WIDTH, 10, data memory address width (<=12).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_addr  out  PC_WIDTH  program address (= PC).
- imem_data  in  16  instruction; combinational ROM, valid the same cycle.
- dmem_req  out  1  data memory request.
- dmem_we  out  1  1 = write, 0 = read; valid while dmem_req.
- dmem_addr  out  MEM_ADDR_WIDTH  data address.
- dmem_wdata  out  DATA_WIDTH  write data (= A).
- dmem_rdata  in  DATA_WIDTH  read data; valid when dmem_ready=1.
- dmem_ready  in  1  transfer completes when dmem_req & dmem_ready at a clk edge.
- acc  out  DATA_WIDTH  accumulator A.
- flag_z  out  1  zero flag.
- flag_c  out  1  carry flag.
- halted  out  1  core is in HALT.
- retire  out  1  one-cycle pulse per completed instruction.

Behaviour:
- Reset (async) values:
  - PC=0, IR=0, A=0, Z=0, C=0, all RF entries 0.
  - state=FETCH; dmem_req=0, dmem_we=0, halted=0, retire=0.
  - Any outstanding dmem request is dropped immediately. The memory must tolerate req falling without ready.
- Instruction format: [15:12] opcode, [11:0] operand.
  - r = operand[RF_ADDR_WIDTH-1:0]
  - imm = operand[DATA_WIDTH-1:0]
  - ma = operand[MEM_ADDR_WIDTH-1:0]
  - t = operand[PC_WIDTH-1:0]
  - Upper operand bits are ignored.
- Opcodes:
  - 0 NOP.
  - 1 LDI: A=imm.
  - 2 ADD: {C,A}=A+R[r].
  - 3 SUB: {C,A}=A+~R[r]+1 (C=1 means no borrow).
  - 4 AND, 5 OR, 6 XOR: A=A op R[r].
  - 7 ADC: {C,A}=A+R[r]+C.
  - 8 STR: R[r]=A.
  - 9 LDM: A=mem[ma].
  - A STM: mem[ma]=A.
  - B JMP t.
  - C JZ t: jump if Z=1.
  - D JC t: jump if C=1.
  - E SHL: {C,A}={A,1'b0}.
  - F HLT.
- Flags:
  - Z=(new A==0), updated by opcodes 1-7, 9, E.
  - C updated only by 2, 3, 7, E.
  - STR, STM, jumps, NOP and HLT leave flags unchanged.
  - Arithmetic is modulo 2**DATA_WIDTH; carry is bit DATA_WIDTH of the sum.
- FSM states: FETCH, EXEC, MEM, HALT.
- FETCH (1 cycle): IR<=imem_data; ->EXEC.
- EXEC (1 cycle):
  - Non-memory ops commit A/flags/RF, then PC<=taken?t:PC+1.
  - All other instructions retire with a retire pulse during EXEC and go ->FETCH.
  - LDM/STM: assert dmem_req with addr/we/wdata registered, ->MEM.
  - HLT: ->HALT, no PC change.
- MEM: dmem_req, dmem_we, dmem_addr and dmem_wdata held stable until dmem_ready=1.
  - On that edge: LDM loads A and Z; PC<=PC+1; dmem_req<=0; retire pulse; ->FETCH.
  - A zero-wait memory gives 3 cycles for LDM/STM; all other instructions take 2 cycles.
- HALT: absorbing; halted=1; no further fetch, PC frozen. Only rst exits.
- dmem_ready is ignored whenever dmem_req=0.
- PC+1 wraps from 2**PC_WIDTH-1 to 0.
- Registered outputs: acc, flag_z and flag_c reflect committed state.

Test Plan:
- LDI 5; STR r1; LDI 3; ADD r1 -> A=8, Z=0, C=0; retire pulses 4; ADD retires in cycle 8 after reset release.
- LDI 0xFF; STR r0; LDI 1; ADD r0 -> A=0, Z=1, C=1; then ADC r0 -> A=0x00+0xFF+1=0x00, C=1, Z=1.
- STM 0x3 with A=0x2A, ready delayed 3 cycles -> dmem_req high for 4 cycles with addr=3, we=1, wdata=0x2A constant. Then LDM 0x3 -> A=0x2A, Z=0.
- LDI 0; JZ 7 -> PC=7. Then LDI 1; JZ 0 -> not taken, PC increments. JMP 31 followed by NOP at 31 -> PC wraps to 0.
- HLT -> halted=1 within 2 cycles; imem_addr frozen for 20 cycles; no retire pulses.
- rst asserted mid-MEM (ready held low) -> dmem_req=0 asynchronously, all outputs at reset values. After release, the core refetches from PC=0.
